// File: rtl/rle_pkg.sv
// Shared symbol encodings and helpers for the run-length encoder.
package rle_pkg;

    localparam logic [1:0] KIND_DATA = 2'd0;
    localparam logic [1:0] KIND_ZRL  = 2'd1;
    localparam logic [1:0] KIND_EOB  = 2'd2;
    localparam logic [1:0] KIND_DC   = 2'd3;

    localparam int         ZRL_LEN = 16;
    localparam logic [3:0] ZRL_RUN = 4'd15;

    // Width of one packed symbol {kind, run, coef, last, count}.
    function automatic int sym_w(input int coef_w, input int block_len);
        return 2 + 4 + coef_w + 1 + $clog2(block_len + 1);
    endfunction

endpackage

// File: rtl/rle_lane_select.sv
// Picks the coefficient under the lane pointer out of the holding register (lane 0 in the MSBs).
module rle_lane_select #(
    parameter int COEF_W = 8,
    parameter int LANES  = 8,
    parameter int LANE_W = 3
) (
    input  logic [LANES*COEF_W-1:0] hold_i,
    input  logic [LANE_W-1:0]       lane_i,
    output logic [COEF_W-1:0]       coef_o,
    output logic                    is_zero_o
);

    always_comb begin
        coef_o = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_i == LANE_W'(k)) begin
                coef_o = hold_i[(LANES-1-k)*COEF_W +: COEF_W];
            end
        end
    end

    assign is_zero_o = (coef_o == '0);

endmodule

// File: rtl/rle_stream_enc.sv
// Run-length encoder: buffers one beat, scans it a lane per step and emits registered
// (kind, run, coef) symbols, carrying zero runs across beats within a block.
module rle_stream_enc
    import rle_pkg::*;
#(
    parameter int COEF_W    = 8,
    parameter int LANES     = 8,
    parameter int BLOCK_LEN = 64,
    parameter int SKIP_DC   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*COEF_W-1:0]        in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [1:0]                     out_kind,
    output logic [3:0]                     out_run,
    output logic [COEF_W-1:0]              out_coef,
    output logic                           out_last,
    output logic [$clog2(BLOCK_LEN+1)-1:0] out_count
);

    localparam int BEATS  = BLOCK_LEN / LANES;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ZRUN_W = $clog2(BLOCK_LEN);
    localparam int CNT_W  = $clog2(BLOCK_LEN + 1);

    logic [LANES*COEF_W-1:0] hold_q,  hold_d;
    logic                    full_q,  full_d;
    logic [LANE_W-1:0]       lane_q,  lane_d;
    logic [BEAT_W-1:0]       beat_q,  beat_d;
    logic [ZRUN_W-1:0]       zrun_q,  zrun_d;
    logic [CNT_W-1:0]        sym_q,   sym_d;
    logic                    valid_q, valid_d;
    logic [1:0]              kind_q,  kind_d;
    logic [3:0]              run_q,   run_d;
    logic [COEF_W-1:0]       coef_q,  coef_d;
    logic                    last_q,  last_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic [COEF_W-1:0] lane_coef;
    logic              lane_zero;
    logic              step_en, is_first, is_final;
    logic              emit, advance, e_last;
    logic [1:0]        e_kind;
    logic [3:0]        e_run;
    logic [COEF_W-1:0] e_coef;

    rle_lane_select #(
        .COEF_W (COEF_W),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_select (
        .hold_i    (hold_q),
        .lane_i    (lane_q),
        .coef_o    (lane_coef),
        .is_zero_o (lane_zero)
    );

    assign in_ready  = !full_q;
    assign out_valid = valid_q;
    assign out_kind  = kind_q;
    assign out_run   = run_q;
    assign out_coef  = coef_q;
    assign out_last  = last_q;
    assign out_count = count_q;

    assign step_en  = full_q && (!valid_q || out_ready);
    assign is_first = (beat_q == '0) && (lane_q == '0);
    assign is_final = (beat_q == BEAT_W'(BEATS-1)) && (lane_q == LANE_W'(LANES-1));

    always_comb begin
        hold_d  = hold_q;
        full_d  = full_q;
        lane_d  = lane_q;
        beat_d  = beat_q;
        zrun_d  = zrun_q;
        sym_d   = sym_q;
        valid_d = valid_q;
        kind_d  = kind_q;
        run_d   = run_q;
        coef_d  = coef_q;
        last_d  = last_q;
        count_d = count_q;
        emit    = 1'b0;
        advance = 1'b0;
        e_last  = 1'b0;
        e_kind  = KIND_DATA;
        e_run   = 4'd0;
        e_coef  = '0;

        if (!full_q && in_valid) begin
            hold_d = in_data;
            full_d = 1'b1;
        end

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (step_en) begin
            advance = 1'b1;
            if (is_first && (SKIP_DC != 0)) begin
                emit   = 1'b1;
                e_kind = KIND_DC;
                e_coef = lane_coef;
            end else if (!lane_zero) begin
                // A long run is flushed as ZRLs first; the same lane is revisited until it fits in 4 bits.
                if (int'(zrun_q) >= ZRL_LEN) begin
                    emit    = 1'b1;
                    e_kind  = KIND_ZRL;
                    e_run   = ZRL_RUN;
                    zrun_d  = zrun_q - ZRUN_W'(ZRL_LEN);
                    advance = 1'b0;
                end else begin
                    emit   = 1'b1;
                    e_kind = KIND_DATA;
                    e_run  = zrun_q[3:0];
                    e_coef = lane_coef;
                    e_last = is_final;
                    zrun_d = '0;
                end
            end else if (is_final) begin
                emit   = 1'b1;
                e_kind = KIND_EOB;
                e_last = 1'b1;
            end else begin
                zrun_d = zrun_q + 1'b1;
            end

            if (advance) begin
                if (lane_q == LANE_W'(LANES-1)) begin
                    lane_d = '0;
                    full_d = 1'b0;
                    beat_d = beat_q + 1'b1;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end

            if (emit) begin
                valid_d = 1'b1;
                kind_d  = e_kind;
                run_d   = e_run;
                coef_d  = e_coef;
                last_d  = e_last;
                count_d = e_last ? (sym_q + 1'b1) : '0;
                sym_d   = e_last ? '0 : (sym_q + 1'b1);
            end

            if (e_last) begin
                zrun_d = '0;
                beat_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            full_q  <= 1'b0;
            lane_q  <= '0;
            beat_q  <= '0;
            zrun_q  <= '0;
            sym_q   <= '0;
            valid_q <= 1'b0;
            kind_q  <= '0;
            run_q   <= '0;
            coef_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            hold_q  <= hold_d;
            full_q  <= full_d;
            lane_q  <= lane_d;
            beat_q  <= beat_d;
            zrun_q  <= zrun_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
            kind_q  <= kind_d;
            run_q   <= run_d;
            coef_q  <= coef_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rle_stream_enc.sv
// Directed and randomised checks of rle_stream_enc, including a SKIP_DC=0 instance.
module tb_rle_stream_enc;
    import rle_pkg::*;

    localparam int COEF_W    = 8;
    localparam int LANES     = 8;
    localparam int BLOCK_LEN = 64;
    localparam int BEATS     = BLOCK_LEN / LANES;
    localparam int CNT_W     = 7;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [LANES*COEF_W-1:0] in_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [1:0]              out_kind;
    logic [3:0]              out_run;
    logic [COEF_W-1:0]       out_coef;
    logic                    out_last;
    logic [CNT_W-1:0]        out_count;

    logic                    dut1En = 1'b0;
    logic                    in_valid1;
    logic                    in_ready1;
    logic                    out_valid1;
    logic                    out_ready1 = 1'b1;
    logic [1:0]              out_kind1;
    logic [3:0]              out_run1;
    logic [COEF_W-1:0]       out_coef1;
    logic                    out_last1;
    logic [CNT_W-1:0]        out_count1;

    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] gotQ[$];
    logic [31:0] gotQ1[$];
    logic [31:0] expQ[$];
    logic [7:0]  blk[BLOCK_LEN];
    bit          stallMode = 1'b0;
    bit          prevStalled = 1'b0;
    logic [31:0] heldSym = '0;

    always #5 clk = ~clk;

    assign in_valid1 = in_valid && dut1En;

    rle_stream_enc #(.COEF_W(COEF_W), .LANES(LANES), .BLOCK_LEN(BLOCK_LEN), .SKIP_DC(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_run(out_run),
        .out_coef(out_coef), .out_last(out_last), .out_count(out_count)
    );

    rle_stream_enc #(.COEF_W(COEF_W), .LANES(LANES), .BLOCK_LEN(BLOCK_LEN), .SKIP_DC(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_kind(out_kind1), .out_run(out_run1),
        .out_coef(out_coef1), .out_last(out_last1), .out_count(out_count1)
    );

    function automatic logic [31:0] mkSym(input logic [1:0] k, input logic [3:0] r,
                                          input logic [7:0] c, input logic l, input logic [6:0] n);
        return {10'd0, k, r, c, l, n};
    endfunction

    function automatic logic [31:0] symDc(input logic [7:0] c);
        return mkSym(KIND_DC, 4'd0, c, 1'b0, 7'd0);
    endfunction

    function automatic logic [31:0] symData(input logic [3:0] r, input logic [7:0] c);
        return mkSym(KIND_DATA, r, c, 1'b0, 7'd0);
    endfunction

    function automatic logic [31:0] symZrl();
        return mkSym(KIND_ZRL, 4'd15, 8'd0, 1'b0, 7'd0);
    endfunction

    function automatic logic [31:0] symEob();
        return mkSym(KIND_EOB, 4'd0, 8'd0, 1'b0, 7'd0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic markLast(input int n);
        logic [31:0] tmp;
        tmp = expQ[expQ.size()-1];
        tmp[7] = 1'b1;
        tmp[6:0] = 7'(n);
        expQ[expQ.size()-1] = tmp;
    endtask

    // Reference encoder working from the positions of the nonzero coefficients.
    task automatic buildExpected(input bit skipDc);
        int prev;
        int run;
        expQ.delete();
        prev = skipDc ? 0 : -1;
        if (skipDc) expQ.push_back(symDc(blk[0]));
        for (int j = (skipDc ? 1 : 0); j < BLOCK_LEN; j++) begin
            if (blk[j] != 8'd0) begin
                run = j - prev - 1;
                repeat (run / 16) expQ.push_back(symZrl());
                expQ.push_back(symData(4'(run % 16), blk[j]));
                prev = j;
            end
        end
        if (blk[BLOCK_LEN-1] == 8'd0) expQ.push_back(symEob());
        markLast(expQ.size());
    endtask

    // Consumer: randomises out_ready, logs accepted symbols and checks hold-stability under stall.
    always @(negedge clk) begin
        logic [31:0] curSym;
        curSym = mkSym(out_kind, out_run, out_coef, out_last, out_count);
        if (rst) begin
            prevStalled = 1'b0;
            out_ready = 1'b1;
        end else begin
            if (prevStalled) begin
                checkOutput("stall_hold", {out_valid, curSym[30:0]}, {1'b1, heldSym[30:0]});
            end
            out_ready = stallMode ? ($urandom_range(0, 99) >= 30) : 1'b1;
            if (out_valid && out_ready) gotQ.push_back(curSym);
            prevStalled = out_valid && !out_ready;
            heldSym = curSym;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1) begin
            gotQ1.push_back(mkSym(out_kind1, out_run1, out_coef1, out_last1, out_count1));
        end
    end

    task automatic applyStimulus(input int firstBeat, input int lastBeat);
        int t;
        for (int b = firstBeat; b <= lastBeat; b++) begin
            @(negedge clk);
            for (int k = 0; k < LANES; k++) begin
                in_data[(LANES-1-k)*COEF_W +: COEF_W] = blk[b*LANES+k];
            end
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic runBlock(input string name);
        int t;
        gotQ.delete();
        applyStimulus(0, BEATS-1);
        t = 0;
        while (gotQ.size() < expQ.size() && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (LANES + 4) @(negedge clk);
        checkOutput({name, "_count"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_sym%0d", name, i),
                        (i < gotQ.size()) ? gotQ[i] : 32'hFFFF_FFFF, expQ[i]);
        end
    endtask

    task automatic clearBlock();
        for (int j = 0; j < BLOCK_LEN; j++) blk[j] = 8'd0;
    endtask

    initial begin
        int dens;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_sym", mkSym(out_kind, out_run, out_coef, out_last, out_count), 32'd0);
        rst = 1'b0;

        // All-zero block on both instances.
        clearBlock();
        dut1En = 1'b1;
        gotQ1.delete();
        expQ.delete();
        expQ.push_back(symDc(8'd0));
        expQ.push_back(symEob());
        markLast(2);
        runBlock("allzero");
        dut1En = 1'b0;
        checkOutput("nodc_count", gotQ1.size(), 32'd1);
        checkOutput("nodc_sym0", (gotQ1.size() > 0) ? gotQ1[0] : 32'hFFFF_FFFF,
                    mkSym(KIND_EOB, 4'd0, 8'd0, 1'b1, 7'd1));

        clearBlock();
        blk[0] = 8'd5; blk[3] = 8'hFE; blk[63] = 8'd7;
        expQ.delete();
        expQ.push_back(symDc(8'd5));
        expQ.push_back(symData(4'd2, 8'hFE));
        repeat (3) expQ.push_back(symZrl());
        expQ.push_back(symData(4'd11, 8'd7));
        markLast(6);
        runBlock("lastnz");

        clearBlock();
        blk[17] = 8'd1;
        expQ.delete();
        expQ.push_back(symDc(8'd0));
        expQ.push_back(symZrl());
        expQ.push_back(symData(4'd0, 8'd1));
        expQ.push_back(symEob());
        markLast(4);
        runBlock("span");

        clearBlock();
        blk[40] = 8'd3;
        expQ.delete();
        expQ.push_back(symDc(8'd0));
        expQ.push_back(symZrl());
        expQ.push_back(symZrl());
        expQ.push_back(symData(4'd7, 8'd3));
        expQ.push_back(symEob());
        markLast(5);
        runBlock("trail");

        stallMode = 1'b1;
        for (int b = 0; b < 100; b++) begin
            dens = (b % 3 == 0) ? 3 : ((b % 3 == 1) ? 15 : 60);
            for (int j = 0; j < BLOCK_LEN; j++) begin
                blk[j] = ($urandom_range(0, 99) < dens) ? 8'($urandom_range(1, 255)) : 8'd0;
            end
            buildExpected(1'b1);
            runBlock($sformatf("rand%0d", b));
        end
        stallMode = 1'b0;

        // Abort a block while its fifth beat is being scanned.
        for (int j = 0; j < BLOCK_LEN; j++) blk[j] = 8'(j + 1);
        applyStimulus(0, 4);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        gotQ.delete();
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        clearBlock();
        blk[0] = 8'd9; blk[20] = 8'h80; blk[21] = 8'd4;
        expQ.delete();
        expQ.push_back(symDc(8'd9));
        expQ.push_back(symZrl());
        expQ.push_back(symData(4'd3, 8'h80));
        expQ.push_back(symData(4'd0, 8'd4));
        expQ.push_back(symEob());
        markLast(5);
        runBlock("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
